// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// The MADD group codes are always defined; mdu_ctrl only honours them when
// MDU_MADD_EN is defined.
package mdu_pkg;

  localparam int unsigned MDU_ITER_DEFAULT = 32;

  // Divide-by-zero quotient; the remainder naturally comes out equal to rs.
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    OpMult  = 4'h0,
    OpMultu = 4'h1,
    OpDiv   = 4'h2,
    OpDivu  = 4'h3,
    OpMthi  = 4'h4,
    OpMtlo  = 4'h5,
    OpMfhi  = 4'h6,
    OpMflo  = 4'h7,
    OpMadd  = 4'h8,
    OpMaddu = 4'h9,
    OpMsub  = 4'hA,
    OpMsubu = 4'hB
  } mdu_op_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } mdu_state_t;

  // Two's-complement negate when neg is set.
  function automatic logic [31:0] mdu_neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Iterative datapath: 32x32 shift-add multiply or restoring divide on unsigned
// operands. After 32 steps acc_o holds {hi, lo} of the product, or
// {remainder, quotient} for a divide. Sequencing is owned by the caller.
module mdu_shift_core (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [63:0] acc_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [32:0] sum;

  // Next accumulator: load operands, or one multiply/divide step.
  always_comb begin
    acc_d  = acc_q;
    b_d    = b_q;
    // Divide: remainder shifted left with the next dividend bit brought in.
    rem_sh = acc_q[63:31];
    diff   = rem_sh - {1'b0, b_q};
    // Multiply: add multiplicand into the upper half when the low bit is set.
    sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    if (load_i) begin
      acc_d = {32'd0, op_a_i};
      b_d   = op_b_i;
    end else if (step_i) begin
      if (is_div_i) begin
        // Remainder stays below the divisor, so diff[32] is a true borrow.
        if (!diff[32]) begin
          acc_d = {diff[31:0], acc_q[30:0], 1'b1};
        end else begin
          acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
        end
      end else begin
        acc_d = {sum, acc_q[31:1]};
      end
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      b_q   <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning the architectural HI/LO registers.
// Optional feature macro: MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which
// accumulate the product into {HI,LO} at the end of the multiply path.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MDU_ITER = MDU_ITER_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mdu_start,
  input  logic [3:0]  i_mdu_op,
  input  logic [31:0] i_mdu_rs,
  input  logic [31:0] i_mdu_rt,
  input  logic        i_mdu_kill,
  output logic        o_mdu_busy,
  output logic        o_mdu_stall,
  output logic [31:0] o_mdu_rdata,
  output logic [31:0] o_mdu_hi,
  output logic [31:0] o_mdu_lo
);

  localparam int unsigned CntW = (MDU_ITER > 1) ? $clog2(MDU_ITER) : 1;

  mdu_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        div0_q, div0_d;
`ifdef MDU_MADD_EN
  logic        acc_q, acc_d;
  logic        sub_q, sub_d;
  logic        op_acc, op_sub;
`endif

  logic        op_md, op_div, op_signed, op_valid, accept;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [63:0] core_acc, prod, mul_res;
  logic [31:0] quot, rem;

  // Opcode decode; unlisted codes are ignored entirely.
  always_comb begin
    op_md     = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    op_valid  = 1'b0;
`ifdef MDU_MADD_EN
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`endif
    case (i_mdu_op)
      OpMult:  begin op_md = 1'b1; op_signed = 1'b1; op_valid = 1'b1; end
      OpMultu: begin op_md = 1'b1; op_valid = 1'b1; end
      OpDiv:   begin op_md = 1'b1; op_div = 1'b1; op_signed = 1'b1; op_valid = 1'b1; end
      OpDivu:  begin op_md = 1'b1; op_div = 1'b1; op_valid = 1'b1; end
      OpMthi, OpMtlo, OpMfhi, OpMflo: op_valid = 1'b1;
`ifdef MDU_MADD_EN
      OpMadd:  begin op_md = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_valid = 1'b1; end
      OpMaddu: begin op_md = 1'b1; op_acc = 1'b1; op_valid = 1'b1; end
      OpMsub:  begin
        op_md = 1'b1; op_signed = 1'b1; op_acc = 1'b1; op_sub = 1'b1; op_valid = 1'b1;
      end
      OpMsubu: begin op_md = 1'b1; op_acc = 1'b1; op_sub = 1'b1; op_valid = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign a_neg = op_signed & i_mdu_rs[31];
  assign b_neg = op_signed & i_mdu_rt[31];
  assign abs_a = mdu_neg_if(a_neg, i_mdu_rs);
  assign abs_b = mdu_neg_if(b_neg, i_mdu_rt);

  assign o_mdu_busy  = (state_q != StIdle);
  assign o_mdu_stall = i_mdu_start & o_mdu_busy & op_valid;
  assign accept      = i_mdu_start & ~o_mdu_busy & ~i_mdu_kill & op_valid;

  mdu_shift_core u_core (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .load_i   (accept & op_md),
    .step_i   ((state_q == StRun) & ~i_mdu_kill),
    .is_div_i (is_div_q),
    .op_a_i   (abs_a),
    .op_b_i   (abs_b),
    .acc_o    (core_acc)
  );

  // Sign-corrected results presented to the FIX write.
  assign prod = neg_res_q ? (~core_acc + 64'd1) : core_acc;
`ifdef MDU_MADD_EN
  assign mul_res = !acc_q ? prod :
                   sub_q  ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
`else
  assign mul_res = prod;
`endif
  assign quot = div0_q ? MDU_DIV0_LO : mdu_neg_if(neg_res_q, core_acc[31:0]);
  assign rem  = mdu_neg_if(neg_rem_q, core_acc[63:32]);

  // MF read reflects HI/LO before any write landing at the next edge.
  always_comb begin
    o_mdu_rdata = '0;
    if (i_mdu_start && (i_mdu_op == OpMfhi)) begin
      o_mdu_rdata = hi_q;
    end else if (i_mdu_start && (i_mdu_op == OpMflo)) begin
      o_mdu_rdata = lo_q;
    end
  end

  // Next-state: accept in IDLE, count steps in RUN, write back in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
`ifdef MDU_MADD_EN
    acc_d     = acc_q;
    sub_d     = sub_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_md) begin
            state_d   = StRun;
            cnt_d     = CntW'(MDU_ITER - 1);
            is_div_d  = op_div;
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            div0_d    = op_div & (i_mdu_rt == 32'd0);
`ifdef MDU_MADD_EN
            acc_d     = op_acc;
            sub_d     = op_sub;
`endif
          end else if (i_mdu_op == OpMthi) begin
            hi_d = i_mdu_rs;
          end else if (i_mdu_op == OpMtlo) begin
            lo_d = i_mdu_rs;
          end
        end
      end
      StRun: begin
        if (i_mdu_kill) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        state_d = StIdle;
        if (!i_mdu_kill) begin
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = mul_res[63:32];
            lo_d = mul_res[31:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, counter, HI/LO and operation flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q     <= 1'b0;
      sub_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
`ifdef MDU_MADD_EN
      acc_q     <= acc_d;
      sub_q     <= sub_d;
`endif
    end
  end

  assign o_mdu_hi = hi_q;
  assign o_mdu_lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl. Inputs change on the falling
// edge; outputs are sampled on the falling edge or shortly after it.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;
  logic        kill = 1'b0;
  logic        busy, stall;
  logic [31:0] rdata, hi, lo;

  int errors = 0;
  int checks = 0;
  int n;

  mdu_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_mdu_start (start),
    .i_mdu_op    (op),
    .i_mdu_rs    (rs),
    .i_mdu_rt    (rt),
    .i_mdu_kill  (kill),
    .o_mdu_busy  (busy),
    .o_mdu_stall (stall),
    .o_mdu_rdata (rdata),
    .o_mdu_hi    (hi),
    .o_mdu_lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle request; returns on the falling edge after the sampling edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    rs    = a;
    rt    = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_md(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int cyc;
    issue(o, a, b);
    wait_idle(cyc);
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Multiply / divide results and latency
    run_md("mult_m3x7", OpMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_5_0", OpDiv, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_md("div_min_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // MT writes land next edge without going busy
    issue(OpMtlo, 32'h0000_1234, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_1234);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    issue(OpMthi, 32'h0000_5678, 32'd0);
    chk("mthi_hi", hi, 32'h0000_5678);

    // MF reads are combinational
    @(negedge clk);
    start = 1'b1;
    op    = OpMfhi;
    #1 chk("mfhi_rdata", rdata, 32'h0000_5678);
    op = OpMflo;
    #1 chk("mflo_rdata", rdata, 32'h0000_1234);
    start = 1'b0;

    // MFHI during a multiply stalls until the write-back, then sees new HI
    issue(OpMult, 32'hFFFF_FFFA, 32'd7);
    repeat (3) @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = OpMfhi;
    #1 chk("mf_stall_high", {31'd0, stall}, 32'd1);
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mf_stall_cycles", 32'(n), 32'd29);
    chk("mf_rdata_new_hi", rdata, 32'hFFFF_FFFF);
    chk("mf_lo", lo, 32'hFFFF_FFD6);
    start = 1'b0;

    // Kill mid-RUN leaves HI/LO alone; start in the kill cycle is dropped
    issue(OpMthi, 32'hA5A5_A5A5, 32'd0);
    issue(OpMtlo, 32'hA5A5_A5A5, 32'd0);
    issue(OpDivu, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    kill  = 1'b1;
    start = 1'b1;
    op    = OpMthi;
    rs    = 32'd0;
    #1 chk("kill_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    kill  = 1'b0;
    start = 1'b0;
    chk("kill_busy_after", {31'd0, busy}, 32'd0);
    chk("kill_hi", hi, 32'hA5A5_A5A5);
    chk("kill_lo", lo, 32'hA5A5_A5A5);
    @(negedge clk);
    kill  = 1'b1;
    start = 1'b1;
    op    = OpMtlo;
    rs    = 32'd0;
    @(negedge clk);
    kill  = 1'b0;
    start = 1'b0;
    chk("kill_idle_mt_lo", lo, 32'hA5A5_A5A5);

    // Unused opcode: no stall even while busy, no effect in idle
    issue(OpMultu, 32'd1, 32'd1);
    start = 1'b1;
    op    = 4'hF;
    #1 chk("unused_no_stall", {31'd0, stall}, 32'd0);
    start = 1'b0;
    wait_idle(n);
    chk("unused_mul_lo", lo, 32'd1);
    issue(4'hF, 32'hDEAD_BEEF, 32'd3);
    chk("unused_idle_busy", {31'd0, busy}, 32'd0);
    chk("unused_idle_hi", hi, 32'd0);

    // Reset mid-RUN clears everything immediately
    issue(OpMthi, 32'hA5A5_A5A5, 32'd0);
    issue(OpMult, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MDU_MADD_EN
    issue(OpMtlo, 32'hFFFF_FFFF, 32'd0);
    run_md("madd_2x3", OpMadd, 32'd2, 32'd3, 32'd1, 32'd5);
    run_md("msub_2x3", OpMsub, 32'd2, 32'd3, 32'd0, 32'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
